// File: rtl/game_sequencer_pkg.sv
// Shared game constants: screen geometry, round-controller state encodings and default tick counts.
package game_sequencer_pkg;

    localparam int unsigned SCREEN_HEIGHT   = 480;

    localparam int unsigned DEF_SCORE_W     = 10;
    localparam int unsigned DEF_Y_W         = 11;
    localparam int unsigned DEF_FLAP_LOCK   = 3;
    localparam int unsigned DEF_DEATH_TICKS = 120;
    localparam int unsigned DEF_OVER_HOLD   = 60;
    localparam int unsigned DEF_BLINK_TICKS = 30;

    localparam int unsigned STATE_W         = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_ATTRACT = 3'd0,
        ST_ARM     = 3'd1,
        ST_PLAY    = 3'd2,
        ST_DYING   = 3'd3,
        ST_OVER    = 3'd4
    } state_e;

endpackage : game_sequencer_pkg

// File: rtl/game_sequencer_btn_sync_edge.sv
// Two-flop synchroniser for the raw pushbutton plus a registered one-tick rising-edge pulse.
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic press_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            press_q <= sync2_q & ~prev_q;
        end
    end

    assign press_o = press_q;

endmodule : btn_sync_edge

// File: rtl/game_sequencer.sv
// Round controller: attract -> arm -> play -> dying -> over, flap conditioning,
// datapath gating and session high score.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int unsigned SCORE_W     = DEF_SCORE_W,
    parameter int unsigned Y_W         = DEF_Y_W,
    parameter int unsigned FLAP_LOCK   = DEF_FLAP_LOCK,
    parameter int unsigned DEATH_TICKS = DEF_DEATH_TICKS,
    parameter int unsigned OVER_HOLD   = DEF_OVER_HOLD,
    parameter int unsigned BLINK_TICKS = DEF_BLINK_TICKS
) (
    input  logic               gameClk,
    input  logic               reset_n,
    input  logic               button,
    input  logic               hitColumn,
    input  logic               passColumn,
    input  logic [Y_W-1:0]     bird_y,
    input  logic [SCORE_W-1:0] score,
    output logic               run,
    output logic               round_clr,
    output logic               flap,
    output logic               pass_gated,
    output logic [SCORE_W-1:0] high_score,
    output logic [2:0]         state_o,
    output logic               blink
);

    localparam int unsigned LOCK_W  = $clog2(FLAP_LOCK + 1);
    localparam int unsigned DIE_W   = $clog2(DEATH_TICKS + 1);
    localparam int unsigned HOLD_W  = $clog2(OVER_HOLD + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);

    localparam logic [LOCK_W-1:0]  LOCK_LOAD = LOCK_W'(FLAP_LOCK);
    localparam logic [DIE_W-1:0]   DIE_MAX   = DIE_W'(DEATH_TICKS - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(OVER_HOLD - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_TICKS - 1);

    logic press;

    state_e               state_q, state_d;
    logic [LOCK_W-1:0]    lock_q, lock_d;
    logic [DIE_W-1:0]     die_q, die_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_q, blink_d;
    logic                 flap_q, flap_d;
    logic                 run_q, run_d;
    logic                 clr_q, clr_d;
    logic [SCORE_W-1:0]   high_q, high_d;

    btn_sync_edge u_btn (
        .clk_i   (gameClk),
        .rst_ni  (reset_n),
        .btn_i   (button),
        .press_o (press)
    );

    always_ff @(posedge gameClk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ATTRACT;
            lock_q      <= '0;
            die_q       <= '0;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            flap_q      <= 1'b0;
            run_q       <= 1'b0;
            clr_q       <= 1'b0;
            high_q      <= '0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            die_q       <= die_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            flap_q      <= flap_d;
            run_q       <= run_d;
            clr_q       <= clr_d;
            high_q      <= high_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lock_d      = '0;
        die_d       = '0;
        hold_d      = '0;
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        flap_d      = 1'b0;
        high_d      = high_q;

        case (state_q)
            ST_ATTRACT: begin
                if (press) state_d = ST_ARM;
            end
            ST_ARM: begin
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                lock_d = (lock_q != '0) ? lock_q - 1'b1 : '0;
                // A fatal hit takes priority over any flap request on the same tick.
                if (hitColumn) begin
                    state_d = ST_DYING;
                    if (score > high_q) high_d = score;
                end else if (press && lock_q == '0) begin
                    flap_d = 1'b1;
                    lock_d = LOCK_LOAD;
                end
            end
            ST_DYING: begin
                if (bird_y == '0 || die_q == DIE_MAX) state_d = ST_OVER;
                else                                  die_d   = die_q + 1'b1;
            end
            ST_OVER: begin
                if (hold_q == HOLD_MAX) begin
                    hold_d = hold_q;
                    if (press) state_d = ST_ARM;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ATTRACT;
            end
        endcase

        // Registered outputs follow the state being entered so they line up with state_o.
        run_d = (state_d == ST_PLAY);
        clr_d = (state_d == ST_ARM);

        if (state_d == ST_OVER) begin
            if (state_q != ST_OVER) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_MAX) begin
                blink_d = ~blink_q;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    assign pass_gated = passColumn & (state_q == ST_PLAY) & ~hitColumn;
    assign run        = run_q;
    assign round_clr  = clr_q;
    assign flap       = flap_q;
    assign high_score = high_q;
    assign state_o    = 3'(state_q);
    assign blink      = blink_q;

endmodule : game_sequencer

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: vector table for start/flap/hit, hand sequences for timing corners.
module tb_game_sequencer;

    logic        gameClk;
    logic        reset_n;
    logic        button;
    logic        hitColumn;
    logic        passColumn;
    logic [10:0] bird_y;
    logic [9:0]  score;
    logic        run;
    logic        round_clr;
    logic        flap;
    logic        pass_gated;
    logic [9:0]  high_score;
    logic [2:0]  state_o;
    logic        blink;

    int checks = 0;
    int errors = 0;

    game_sequencer dut (
        .gameClk    (gameClk),
        .reset_n    (reset_n),
        .button     (button),
        .hitColumn  (hitColumn),
        .passColumn (passColumn),
        .bird_y     (bird_y),
        .score      (score),
        .run        (run),
        .round_clr  (round_clr),
        .flap       (flap),
        .pass_gated (pass_gated),
        .high_score (high_score),
        .state_o    (state_o),
        .blink      (blink)
    );

    initial gameClk = 1'b0;
    always #5 gameClk = ~gameClk;

    typedef struct {
        logic        btn;
        logic        hit;
        logic        pass;
        logic [10:0] by;
        logic [9:0]  sc;
        logic [2:0]  st;
        logic        run;
        logic        clr;
        logic        flp;
        logic        pg;
        logic [9:0]  hs;
        logic        blk;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(logic btn, logic hit, logic pass, int by, int sc,
                                int st, logic r, logic c, logic f, logic pg, int hs, logic bk);
        vec_t v;
        v.btn = btn; v.hit = hit; v.pass = pass;
        v.by  = 11'(by); v.sc = 10'(sc); v.st = 3'(st);
        v.run = r; v.clr = c; v.flp = f; v.pg = pg; v.hs = 10'(hs); v.blk = bk;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge gameClk);
        #1;
    endtask

    // From OVER tick 1: wait for the hold to saturate, press, and walk through ARM into PLAY.
    task automatic over_to_play(input string tag);
        repeat (57) step();
        button = 1'b1;
        repeat (3) step();
        button = 1'b0;
        step();
        chk({tag, " arm state"}, int'(state_o), 1);
        step();
        chk({tag, " play state"}, int'(state_o), 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            btn hit pas  by  sc  st run clr flp pg hs blk
        vecs[0]  = mk(1, 0, 0, 100, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 100, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 100, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 100, 0,  1, 0, 1, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 100, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 100, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 100, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 0, 0, 100, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 100, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 0, 0, 100, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 100, 0,  2, 1, 0, 1, 0, 0, 0);
        vecs[11] = mk(1, 0, 0, 100, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 100, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[13] = mk(1, 0, 0, 100, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, 100, 0,  2, 1, 0, 1, 0, 0, 0);
        vecs[15] = mk(1, 0, 0, 100, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 100, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[17] = mk(0, 0, 0, 100, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 100, 0,  2, 1, 0, 1, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 100, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[20] = mk(0, 0, 1, 100, 0,  2, 1, 0, 0, 1, 0, 0);
        vecs[21] = mk(0, 1, 1, 100, 7,  3, 0, 0, 0, 0, 7, 0);
        vecs[22] = mk(0, 0, 1, 200, 7,  3, 0, 0, 0, 0, 7, 0);
        vecs[23] = mk(0, 0, 0, 0,   7,  4, 0, 0, 0, 0, 7, 1);

        reset_n    = 1'b0;
        button     = 1'b0;
        hitColumn  = 1'b0;
        passColumn = 1'b0;
        bird_y     = 11'd100;
        score      = 10'd0;
        repeat (2) @(posedge gameClk);
        #1;
        chk("reset state", int'(state_o), 0);
        chk("reset run", int'(run), 0);
        chk("reset round_clr", int'(round_clr), 0);
        chk("reset flap", int'(flap), 0);
        chk("reset blink", int'(blink), 0);
        chk("reset high_score", int'(high_score), 0);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            button     = vecs[i].btn;
            hitColumn  = vecs[i].hit;
            passColumn = vecs[i].pass;
            bird_y     = vecs[i].by;
            score      = vecs[i].sc;
            #1;
            chk($sformatf("v%0d pass_gated", i), int'(pass_gated), int'(vecs[i].pg));
            @(posedge gameClk);
            #1;
            chk($sformatf("v%0d state", i), int'(state_o), int'(vecs[i].st));
            chk($sformatf("v%0d run", i), int'(run), int'(vecs[i].run));
            chk($sformatf("v%0d round_clr", i), int'(round_clr), int'(vecs[i].clr));
            chk($sformatf("v%0d flap", i), int'(flap), int'(vecs[i].flp));
            chk($sformatf("v%0d high_score", i), int'(high_score), int'(vecs[i].hs));
            chk($sformatf("v%0d blink", i), int'(blink), int'(vecs[i].blk));
        end

        // OVER hold and blink: now at OVER tick 1.
        repeat (26) step();
        button = 1'b1;
        repeat (3) step();
        chk("over t30 state", int'(state_o), 4);
        chk("over t30 blink", int'(blink), 1);
        button = 1'b0;
        step();
        chk("over t31 press ignored", int'(state_o), 4);
        chk("over t31 blink", int'(blink), 0);
        repeat (27) step();
        button = 1'b1;
        repeat (3) step();
        chk("over t61 state", int'(state_o), 4);
        chk("over t61 blink", int'(blink), 1);
        button = 1'b0;
        step();
        chk("rearm state", int'(state_o), 1);
        chk("rearm round_clr", int'(round_clr), 1);
        chk("rearm blink", int'(blink), 0);
        step();
        chk("replay state", int'(state_o), 2);
        chk("replay run", int'(run), 1);
        chk("replay round_clr", int'(round_clr), 0);

        // Round 2: hit and press on the same tick, lower score, full death timeout.
        button = 1'b1;
        repeat (3) step();
        button    = 1'b0;
        hitColumn = 1'b1;
        score     = 10'd5;
        step();
        chk("hit+press state", int'(state_o), 3);
        chk("hit+press flap", int'(flap), 0);
        chk("hit+press run", int'(run), 0);
        chk("lower score high_score", int'(high_score), 7);
        hitColumn = 1'b0;
        bird_y    = 11'd200;
        repeat (119) step();
        chk("dying tick 120 state", int'(state_o), 3);
        step();
        chk("death timeout state", int'(state_o), 4);
        chk("death timeout blink", int'(blink), 1);

        // Round 3: raise high score to 9, then reset mid-PLAY.
        over_to_play("r3");
        score     = 10'd9;
        hitColumn = 1'b1;
        step();
        chk("r3 hit state", int'(state_o), 3);
        chk("r3 high_score", int'(high_score), 9);
        hitColumn = 1'b0;
        bird_y    = 11'd0;
        step();
        chk("ground over state", int'(state_o), 4);
        over_to_play("r4");
        chk("r4 run", int'(run), 1);
        chk("r4 high_score", int'(high_score), 9);

        reset_n = 1'b0;
        #1;
        chk("async reset state", int'(state_o), 0);
        chk("async reset run", int'(run), 0);
        chk("async reset high_score", int'(high_score), 0);
        chk("async reset flap", int'(flap), 0);
        chk("async reset round_clr", int'(round_clr), 0);
        chk("async reset blink", int'(blink), 0);
        @(posedge gameClk);
        #1;
        reset_n = 1'b1;
        step();
        chk("post reset state", int'(state_o), 0);
        chk("post reset high_score", int'(high_score), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_game_sequencer
